// File: rtl/div_pkg.sv
// Shared types and helpers for the iterative divider.
package div_pkg;

   localparam int DIV_XLEN  = 32;
   localparam int DIV_STEPS = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } div_state_t;

   // Magnitude as unsigned 32-bit, so the most negative value maps onto itself.
   function automatic logic [DIV_XLEN-1:0] abs32(input logic [DIV_XLEN-1:0] value,
                                                 input logic                sign);
      if (sign && value[DIV_XLEN-1]) begin
         abs32 = ~value + 32'd1;
      end else begin
         abs32 = value;
      end
   endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division step on the {rem, quo} pair.
module div_step
   import div_pkg::*;
(
   input  logic [DIV_XLEN-1:0] rem,
   input  logic [DIV_XLEN-1:0] quo,
   input  logic [DIV_XLEN-1:0] divisor,
   output logic [DIV_XLEN-1:0] rem_next,
   output logic [DIV_XLEN-1:0] quo_next
);

   logic [DIV_XLEN:0] shifted_s;
   logic [DIV_XLEN:0] trial_s;

   // Shift in the next dividend bit and keep the trial difference when it does not borrow.
   always_comb begin
      shifted_s = {rem, quo[DIV_XLEN-1]};
      trial_s   = shifted_s - {1'b0, divisor};
      if (!trial_s[DIV_XLEN]) begin
         rem_next = trial_s[DIV_XLEN-1:0];
         quo_next = {quo[DIV_XLEN-2:0], 1'b1};
      end else begin
         rem_next = shifted_s[DIV_XLEN-1:0];
         quo_next = {quo[DIV_XLEN-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/div_ctrl.sv
// EXE-stage divider sequencer: sign handling, 32-step iteration and result hand-off.
// Optional DIV_EARLY_OUT_EN: skip iteration when |divisor| > |dividend|.
module div_ctrl
   import div_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int CNT_W = 6
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            div_enable,
   input  logic            div_sign,
   input  logic [XLEN-1:0] div_dividend,
   input  logic [XLEN-1:0] div_divisor,
   input  logic            div_accept,
   input  logic            flush,
   output logic            div_complete,
   output logic [XLEN-1:0] div_quotient,
   output logic [XLEN-1:0] div_remainder
);

   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DIV_STEPS - 1);

   div_state_t         state_r;
   div_state_t         state_next_s;
   logic [CNT_W-1:0]   cnt_r;
   logic [XLEN-1:0]    rem_r;
   logic [XLEN-1:0]    quo_r;
   logic [XLEN-1:0]    divisor_r;
   logic               q_neg_r;
   logic               r_neg_r;
   logic [XLEN-1:0]    a_abs_s;
   logic [XLEN-1:0]    b_abs_s;
   logic [XLEN-1:0]    rem_next_s;
   logic [XLEN-1:0]    quo_next_s;
   logic               early_s;

   assign a_abs_s = abs32(div_dividend, div_sign);
   assign b_abs_s = abs32(div_divisor, div_sign);

`ifdef DIV_EARLY_OUT_EN
   assign early_s = (b_abs_s != 32'd0) && (b_abs_s > a_abs_s);
`else
   assign early_s = 1'b0;
`endif

   div_step u_step (
      .rem      (rem_r),
      .quo      (quo_r),
      .divisor  (divisor_r),
      .rem_next (rem_next_s),
      .quo_next (quo_next_s)
   );

   // Next-state decode; flush overrides start and accept.
   always_comb begin
      state_next_s = state_r;
      if (flush) begin
         state_next_s = IDLE;
      end else begin
         case (state_r)
            IDLE: begin
               if (div_enable) begin
                  state_next_s = early_s ? FIX : BUSY;
               end else begin
                  state_next_s = IDLE;
               end
            end
            BUSY: begin
               if (!div_enable) begin
                  state_next_s = IDLE;
               end else if (cnt_r == LAST_STEP) begin
                  state_next_s = FIX;
               end else begin
                  state_next_s = BUSY;
               end
            end
            FIX: begin
               if (!div_enable) begin
                  state_next_s = IDLE;
               end else begin
                  state_next_s = DONE;
               end
            end
            DONE: begin
               if (div_accept) begin
                  state_next_s = IDLE;
               end else begin
                  state_next_s = DONE;
               end
            end
            default: state_next_s = IDLE;
         endcase
      end
   end

   // State, datapath and registered result outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r       <= IDLE;
         cnt_r         <= '0;
         rem_r         <= 32'd0;
         quo_r         <= 32'd0;
         divisor_r     <= 32'd0;
         q_neg_r       <= 1'b0;
         r_neg_r       <= 1'b0;
         div_complete  <= 1'b0;
         div_quotient  <= 32'd0;
         div_remainder <= 32'd0;
      end else begin
         state_r      <= state_next_s;
         div_complete <= (state_next_s == DONE);
         case (state_r)
            IDLE: begin
               if (state_next_s != IDLE) begin
                  divisor_r <= b_abs_s;
                  q_neg_r   <= div_sign & (div_dividend[XLEN-1] ^ div_divisor[XLEN-1]);
                  r_neg_r   <= div_sign & div_dividend[XLEN-1];
                  cnt_r     <= '0;
                  if (early_s) begin
                     quo_r <= 32'd0;
                     rem_r <= a_abs_s;
                  end else begin
                     quo_r <= a_abs_s;
                     rem_r <= 32'd0;
                  end
               end
            end
            BUSY: begin
               rem_r <= rem_next_s;
               quo_r <= quo_next_s;
               cnt_r <= cnt_r + CNT_W'(1);
            end
            FIX: begin
               if (state_next_s == DONE) begin
                  div_quotient  <= q_neg_r ? (~quo_r + 32'd1) : quo_r;
                  div_remainder <= r_neg_r ? (~rem_r + 32'd1) : rem_r;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule
